alu_arbiter: RTL and testbench

Round-robin arbiter that shares one instance of the 32-bit ALU between NUM_REQ requesters (e.g. EX stage, address generator, branch-compare unit).
- Each requester presents operands and a 3-bit op over a valid/ready channel.
- The arbiter grants one requester, registers its operands and runs the ALU for one cycle.
- It returns a registered result and zero flag over a per-requester response handshake.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu.sv | 25 ++
 rtl/rr_pick.sv | 29 ++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: op codes, datapath width and arbiter FSM states.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add, sub, and, or; any op with bit 2 set yields zero.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a_i,
    input  logic [ALU_W-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [ALU_W-1:0] result_o,
    output logic             zero_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of req_valid_i searching upward from rr_ptr_i with wrap.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic               grant_valid_o,
    output logic [ID_W-1:0]    grant_idx_o
);

    int idx;

    // Walk the search order backwards so the nearest candidate is the last one written.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_TIMEOUT_EN to drop responses left unaccepted for RSP_TIMEOUT RESP cycles.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int RSP_TIMEOUT = 16,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ALU_W-1:0] req_a,
    input  logic [NUM_REQ*ALU_W-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]     req_op,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [ALU_W-1:0]         rsp_result,
    output logic                     rsp_zero,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_drop
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    arb_state_e         state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [ALU_W-1:0]   op_a_q;
    logic [ALU_W-1:0]   op_b_q;
    logic [2:0]         op_q;
    logic [ALU_W-1:0]   result_q;
    logic               zero_q;
    logic [NUM_REQ-1:0] rsp_valid_q;

    logic               grant_valid;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    next_ptr_d;
    logic [ALU_W-1:0]   alu_result;
    logic               alu_zero;
    logic               rsp_accept;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_valid_i   (req_valid),
        .rr_ptr_i      (rr_ptr_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    alu u_alu (
        .a_i      (op_a_q),
        .b_i      (op_b_q),
        .op_i     (op_q),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    // Valid/ready: a request transfers on the rising edge where req_valid[i] and
    // req_ready[i] are both high; a response transfers when rsp_valid[i] and rsp_ready[i] are.
    // Gating with rst_n keeps req_ready low while reset is held even if requests are pending.
    assign req_ready  = (state_q == ST_IDLE && grant_valid && rst_n) ? (ONE_HOT0 << grant_idx) : '0;
    assign next_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    assign rsp_accept = rsp_ready[rsp_id_q];

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_id     = rsp_id_q;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             rsp_drop_q;
    assign rsp_drop = rsp_drop_q;
`else
    logic unused_timeout;
    assign unused_timeout = (RSP_TIMEOUT > 0);
    assign rsp_drop       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            rsp_id_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_q        <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            rsp_valid_q <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_drop_q  <= 1'b0;
`endif
        end else begin
`ifdef ALU_ARB_TIMEOUT_EN
            rsp_drop_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        op_a_q   <= req_a[ALU_W*grant_idx +: ALU_W];
                        op_b_q   <= req_b[ALU_W*grant_idx +: ALU_W];
                        op_q     <= req_op[3*grant_idx +: 3];
                        rsp_id_q <= grant_idx;
                        rr_ptr_q <= next_ptr_d;
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q    <= alu_result;
                    zero_q      <= alu_zero;
                    rsp_valid_q <= ONE_HOT0 << rsp_id_q;
`ifdef ALU_ARB_TIMEOUT_EN
                    cnt_q       <= '0;
`endif
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    // An accept on the timeout cycle takes priority over the drop.
                    if (rsp_accept) begin
                        rsp_valid_q <= '0;
                        state_q     <= ST_IDLE;
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(RSP_TIMEOUT - 1)) begin
                        rsp_valid_q <= '0;
                        rsp_drop_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single transactions plus fairness,
// backpressure, reset and (with ALU_ARB_TIMEOUT_EN) response timeout sequences.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 4;
`ifdef ALU_ARB_TIMEOUT_EN
    localparam int TMO   = 4;
    localparam int STALL = 2;
`else
    localparam int TMO   = 16;
    localparam int STALL = 5;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N*3-1:0] req_op = '0;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready = '0;
    logic [31:0]    rsp_result;
    logic           rsp_zero;
    logic [1:0]     rsp_id;
    logic           rsp_drop;

    alu_arbiter #(.NUM_REQ(N), .RSP_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_id     (rsp_id),
        .rsp_drop   (rsp_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t       vecs[10];
    logic [1:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int id);
        logic [N-1:0] one;
        one = 1;
        return one << id;
    endfunction

    task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_op[3*id +: 3]  = op;
        req_valid[id]      = 1'b1;
    endtask

    // One full transaction from IDLE with immediate response accept.
    task automatic run_vec(input vec_t v);
        drive_req(v.id, v.a, v.b, v.op);
        #1;
        check("vec_ready", 32'(req_ready), 32'(oh(v.id)));
        tick();
        req_valid[v.id] = 1'b0;
        #1;
        check("vec_exec_ready", 32'(req_ready), 32'd0);
        check("vec_exec_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("vec_rsp_valid", 32'(rsp_valid), 32'(oh(v.id)));
        check("vec_result", rsp_result, v.res);
        check("vec_zero", 32'(rsp_zero), 32'(v.zero));
        check("vec_id", 32'(rsp_id), 32'(v.id));
        rsp_ready[v.id] = 1'b1;
        tick();
        rsp_ready = '0;
        #1;
        check("vec_done", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [1:0] g;
        int         grants;
        int         last_cyc;
        bit         drop_pend;

        vecs[0] = '{0, 32'd5,        32'd3,        3'b001, 32'd2,        1'b0};
        vecs[1] = '{2, 32'd7,        32'd7,        3'b001, 32'd0,        1'b1};
        vecs[2] = '{2, 32'd0,        32'd1,        3'b001, 32'hFFFFFFFF, 1'b0};
        vecs[3] = '{2, 32'd12,       32'd34,       3'b111, 32'd0,        1'b1};
        vecs[4] = '{1, 32'h80000000, 32'h80000000, 3'b000, 32'd0,        1'b1};
        vecs[5] = '{1, 32'h12340000, 32'h00005678, 3'b011, 32'h12345678, 1'b0};
        vecs[6] = '{0, 32'd100,      32'd23,       3'b000, 32'd123,      1'b0};
        vecs[7] = '{3, 32'hFFFF0000, 32'h00FFFF00, 3'b010, 32'h00FF0000, 1'b0};
        vecs[8] = '{0, 32'hDEAD0000, 32'h0000BEEF, 3'b101, 32'd0,        1'b1};
        vecs[9] = '{3, 32'd1,        32'd1,        3'b100, 32'd0,        1'b1};

        // Reset values
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_drop", 32'(rsp_drop), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Fairness: last vector used requester 3, so the search starts at 0.
        foreach (vecs[i]) begin end
        exp_q = {};
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        grants    = 0;
        last_cyc  = -1;
        drop_pend = 1'b0;
        for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
            if (drop_pend) begin
                req_valid[1] = 1'b0;
                drop_pend    = 1'b0;
            end
            #1;
            if (req_ready != '0) begin
                g = 2'd0;
                for (int b = N - 1; b >= 0; b--) if (req_ready[b]) g = 2'(b);
                check("fair_order", 32'(g), 32'(exp_q.pop_front()));
                if (last_cyc >= 0) check("fair_interval", cyc - last_cyc, 32'd3);
                last_cyc = cyc;
                grants++;
                if (grants == 6) drop_pend = 1'b1;
            end
            tick();
        end
        check("fair_all_served", exp_q.size(), 32'd0);
        req_valid = '0;
        repeat (3) tick();
        rsp_ready = '0;

        // Backpressure on requester 3 with requester 0 waiting
        drive_req(3, 32'hF0F0F0F0, 32'h0FF00FF0, ALU_AND);
        #1;
        check("bp_ready", 32'(req_ready), 32'(oh(3)));
        tick();
        req_valid[3] = 1'b0;
        drive_req(0, 32'd1, 32'd1, ALU_ADD);
        #1;
        check("bp_exec_ready", 32'(req_ready), 32'd0);
        tick();
        check("bp_rsp_valid", 32'(rsp_valid), 32'(oh(3)));
        check("bp_result", rsp_result, 32'h00F000F0);
        check("bp_zero", 32'(rsp_zero), 32'd0);
        check("bp_id", 32'(rsp_id), 32'd3);
        rsp_ready = 4'b0111;
        for (int k = 0; k < STALL; k++) begin
            tick();
            check("bp_hold_valid", 32'(rsp_valid), 32'(oh(3)));
            check("bp_hold_result", rsp_result, 32'h00F000F0);
            check("bp_hold_id", 32'(rsp_id), 32'd3);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 4'b1000;
        tick();
        rsp_ready = '0;
        #1;
        check("bp_released", 32'(rsp_valid), 32'd0);
        check("bp_req0_granted", 32'(req_ready), 32'(oh(0)));
        tick();
        req_valid[0] = 1'b0;
        tick();
        check("bp_req0_valid", 32'(rsp_valid), 32'(oh(0)));
        check("bp_req0_result", rsp_result, 32'd2);
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready = '0;

        // Reset during EXEC, then search restarts at 0
        drive_req(1, 32'd9, 32'd4, ALU_SUB);
        #1;
        check("rm_ready", 32'(req_ready), 32'(oh(1)));
        tick();
        drive_req(2, 32'd6, 32'd3, ALU_OR);
        rst_n = 1'b0;
        #1;
        check("rm_req_ready", 32'(req_ready), 32'd0);
        check("rm_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rm_rsp_result", rsp_result, 32'd0);
        check("rm_rsp_zero", 32'(rsp_zero), 32'd0);
        check("rm_rsp_id", 32'(rsp_id), 32'd0);
        check("rm_rsp_drop", 32'(rsp_drop), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rm_first_grant", 32'(req_ready), 32'(oh(1)));
        tick();
        req_valid[1] = 1'b0;
        tick();
        check("rm_req1_valid", 32'(rsp_valid), 32'(oh(1)));
        check("rm_req1_result", rsp_result, 32'd5);
        check("rm_req1_id", 32'(rsp_id), 32'd1);
        rsp_ready[1] = 1'b1;
        tick();
        rsp_ready = '0;
        #1;
        check("rm_second_grant", 32'(req_ready), 32'(oh(2)));
        tick();
        req_valid[2] = 1'b0;
        tick();
        check("rm_req2_result", rsp_result, 32'd7);
        check("rm_req2_id", 32'(rsp_id), 32'd2);
        rsp_ready[2] = 1'b1;
        tick();
        rsp_ready = '0;

`ifdef ALU_ARB_TIMEOUT_EN
        // Response never accepted: dropped after the 4th RESP cycle
        drive_req(0, 32'd1, 32'd2, ALU_ADD);
        tick();
        req_valid[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("to_resp_valid", 32'(rsp_valid), 32'(oh(0)));
            check("to_no_drop_yet", 32'(rsp_drop), 32'd0);
        end
        tick();
        check("to_drop_pulse", 32'(rsp_drop), 32'd1);
        check("to_valid_cleared", 32'(rsp_valid), 32'd0);
        tick();
        check("to_drop_single", 32'(rsp_drop), 32'd0);

        // Accept on the 4th RESP cycle wins over the timeout
        drive_req(0, 32'd1, 32'd2, ALU_ADD);
        tick();
        req_valid[0] = 1'b0;
        repeat (4) tick();
        check("to_late_valid", 32'(rsp_valid), 32'(oh(0)));
        check("to_late_result", rsp_result, 32'd3);
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready = '0;
        check("to_late_done", 32'(rsp_valid), 32'd0);
        check("to_late_no_drop", 32'(rsp_drop), 32'd0);
        tick();
        check("to_late_no_drop2", 32'(rsp_drop), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
